// File: rtl/taus_urng.sv
// taus_urng: dual taus88 uniform random number generator.
//
// Two independent three-component Tausworthe generators (A and B) are
// stepped together. Each advance registers one sample:
//   u0 = {tausA[31:0], tausB[31:16]}  (log/sqrt path)
//   u1 = tausB[15:0]                  (sincos path)
// The output uses a valid/ready handshake and holds while stalled.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   seed_wr    seed register write strobe
//   seed_idx   0-2 = A0..A2, 3-5 = B0..B2, 6-7 ignored
//   seed_data  seed value (floored to a legal taus88 seed on write)
//   seed_go    restart generation from the loaded seeds (LOAD only)
//   out_ready  downstream accepts the current sample
//   out_valid  u0/u1 hold a valid sample
//   u0, u1     sample outputs
//
// Build option: define TAUS_URNG_WARMUP_EN to discard the first 16
// generated samples after reset or seed_go (WARM state).

module taus_urng #(
    parameter logic [31:0] SEED_A0 = 32'h0000_1234,
    parameter logic [31:0] SEED_A1 = 32'h0000_5678,
    parameter logic [31:0] SEED_A2 = 32'h0000_9ABC,
    parameter logic [31:0] SEED_B0 = 32'h1357_0000,
    parameter logic [31:0] SEED_B1 = 32'h2468_0000,
    parameter logic [31:0] SEED_B2 = 32'h369C_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        seed_wr,
    input  logic [2:0]  seed_idx,
    input  logic [31:0] seed_data,
    input  logic        seed_go,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [47:0] u0,
    output logic [15:0] u1
);

`ifdef TAUS_URNG_WARMUP_EN
    typedef enum logic [1:0] {LOAD, WARM, RUN} state_t;
`else
    typedef enum logic [1:0] {LOAD, RUN} state_t;
`endif

    state_t      r_state;
    logic [31:0] r_a0, r_a1, r_a2;
    logic [31:0] r_b0, r_b1, r_b2;
    logic [47:0] r_u0;
    logic [15:0] r_u1;
    logic        r_valid;
`ifdef TAUS_URNG_WARMUP_EN
    logic [3:0]  r_warm;
`endif

    logic [31:0] w_a0, w_a1, w_a2;
    logic [31:0] w_b0, w_b1, w_b2;
    logic [31:0] w_taus_a, w_taus_b;
    logic        w_seed_hit;

    always_comb begin
        w_a0 = ((r_a0 & 32'hFFFF_FFFE) << 12) ^ (((r_a0 << 13) ^ r_a0) >> 19);
        w_a1 = ((r_a1 & 32'hFFFF_FFF8) << 4)  ^ (((r_a1 << 2)  ^ r_a1) >> 25);
        w_a2 = ((r_a2 & 32'hFFFF_FFF0) << 17) ^ (((r_a2 << 3)  ^ r_a2) >> 11);
        w_b0 = ((r_b0 & 32'hFFFF_FFFE) << 12) ^ (((r_b0 << 13) ^ r_b0) >> 19);
        w_b1 = ((r_b1 & 32'hFFFF_FFF8) << 4)  ^ (((r_b1 << 2)  ^ r_b1) >> 25);
        w_b2 = ((r_b2 & 32'hFFFF_FFF0) << 17) ^ (((r_b2 << 3)  ^ r_b2) >> 11);
        w_taus_a = w_a0 ^ w_a1 ^ w_a2;
        w_taus_b = w_b0 ^ w_b1 ^ w_b2;
    end

    // Indices 6 and 7 are not seed registers and leave the FSM untouched.
    assign w_seed_hit = seed_wr && (seed_idx <= 3'd5);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a0    <= SEED_A0 | 32'h0000_0002;
            r_a1    <= SEED_A1 | 32'h0000_0008;
            r_a2    <= SEED_A2 | 32'h0000_0010;
            r_b0    <= SEED_B0 | 32'h0000_0002;
            r_b1    <= SEED_B1 | 32'h0000_0008;
            r_b2    <= SEED_B2 | 32'h0000_0010;
            r_u0    <= '0;
            r_u1    <= '0;
            r_valid <= 1'b0;
`ifdef TAUS_URNG_WARMUP_EN
            r_warm  <= '0;
            r_state <= WARM;
`else
            r_state <= RUN;
`endif
        end else if (w_seed_hit) begin
            // A seed write always wins: no advance, sample dropped, seed_go ignored.
            case (seed_idx)
                3'd0:    r_a0 <= seed_data | 32'h0000_0002;
                3'd1:    r_a1 <= seed_data | 32'h0000_0008;
                3'd2:    r_a2 <= seed_data | 32'h0000_0010;
                3'd3:    r_b0 <= seed_data | 32'h0000_0002;
                3'd4:    r_b1 <= seed_data | 32'h0000_0008;
                default: r_b2 <= seed_data | 32'h0000_0010;
            endcase
            r_valid <= 1'b0;
            r_state <= LOAD;
        end else begin
            case (r_state)
                LOAD: begin
                    r_valid <= 1'b0;
                    if (seed_go) begin
`ifdef TAUS_URNG_WARMUP_EN
                        r_warm  <= '0;
                        r_state <= WARM;
`else
                        r_state <= RUN;
`endif
                    end
                end
`ifdef TAUS_URNG_WARMUP_EN
                WARM: begin
                    r_a0    <= w_a0;
                    r_a1    <= w_a1;
                    r_a2    <= w_a2;
                    r_b0    <= w_b0;
                    r_b1    <= w_b1;
                    r_b2    <= w_b2;
                    r_u0    <= {w_taus_a, w_taus_b[31:16]};
                    r_u1    <= w_taus_b[15:0];
                    r_valid <= 1'b0;
                    r_warm  <= r_warm + 4'd1;
                    if (r_warm == 4'd15) begin
                        r_state <= RUN;
                    end
                end
`endif
                RUN: begin
                    if (!r_valid || out_ready) begin
                        r_a0    <= w_a0;
                        r_a1    <= w_a1;
                        r_a2    <= w_a2;
                        r_b0    <= w_b0;
                        r_b1    <= w_b1;
                        r_b2    <= w_b2;
                        r_u0    <= {w_taus_a, w_taus_b[31:16]};
                        r_u1    <= w_taus_b[15:0];
                        r_valid <= 1'b1;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign out_valid = r_valid;
    assign u0        = r_u0;
    assign u1        = r_u1;

endmodule

// File: tb/tb_taus_urng.sv
module tb_taus_urng;

    logic        clk;
    logic        rst_n;
    logic        seed_wr;
    logic [2:0]  seed_idx;
    logic [31:0] seed_data;
    logic        seed_go;
    logic        out_ready;
    logic        out_valid;
    logic [47:0] u0;
    logic [15:0] u1;

    taus_urng dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seed_wr   (seed_wr),
        .seed_idx  (seed_idx),
        .seed_data (seed_data),
        .seed_go   (seed_go),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .u0        (u0),
        .u1        (u1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef TAUS_URNG_WARMUP_EN
    localparam int WARM_N = 16;
`else
    localparam int WARM_N = 0;
`endif

    int total = 0;
    int bad   = 0;

    // Golden taus88 model state.
    logic [31:0] ma0, ma1, ma2, mb0, mb1, mb2;
    logic [63:0] cur_exp;

    function automatic logic [31:0] t0(input logic [31:0] s);
        return ((s & 32'hFFFF_FFFE) << 12) ^ (((s << 13) ^ s) >> 19);
    endfunction
    function automatic logic [31:0] t1(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF8) << 4) ^ (((s << 2) ^ s) >> 25);
    endfunction
    function automatic logic [31:0] t2(input logic [31:0] s);
        return ((s & 32'hFFFF_FFF0) << 17) ^ (((s << 3) ^ s) >> 11);
    endfunction

    // Returns {u0,u1} == {tausA, tausB} for the next generated sample.
    task automatic next_sample(output logic [63:0] smp);
        ma0 = t0(ma0); ma1 = t1(ma1); ma2 = t2(ma2);
        mb0 = t0(mb0); mb1 = t1(mb1); mb2 = t2(mb2);
        smp = {ma0 ^ ma1 ^ ma2, mb0 ^ mb1 ^ mb2};
    endtask

    task automatic model_restart();
        logic [63:0] dummy;
        for (int i = 0; i < WARM_N; i++) next_sample(dummy);
        next_sample(cur_exp);
    endtask

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Counts clock edges until out_valid is seen; called at a negedge.
    task automatic wait_first_valid(input string name);
        int n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check64(name, 64'(n), 64'(1 + WARM_N));
    endtask

    // Collects n accepted samples; every valid cycle (stalled or not) is compared.
    task automatic stream(input string name, input int n, input bit rnd);
        int  got = 0;
        int  cyc = 0;
        bit  acc;
        while (got < n && cyc < n * 8 + 50) begin
            if (out_valid) check64(name, {u0, u1}, cur_exp);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            acc = out_valid && out_ready;
            @(negedge clk);
            cyc++;
            if (acc) begin
                got++;
                next_sample(cur_exp);
            end
        end
        check64({name, "_count"}, 64'(got), 64'(n));
    endtask

    typedef struct {
        logic ready;
        int   off;
    } stall_vec_t;

    initial begin
        stall_vec_t tbl[10];
        int idx;

        // off = index of the sample that must be on u0/u1 before ready is driven
        tbl[0] = '{1'b0, 0};
        tbl[1] = '{1'b0, 0};
        tbl[2] = '{1'b1, 0};
        tbl[3] = '{1'b1, 1};
        tbl[4] = '{1'b0, 2};
        tbl[5] = '{1'b1, 2};
        tbl[6] = '{1'b0, 3};
        tbl[7] = '{1'b0, 3};
        tbl[8] = '{1'b1, 3};
        tbl[9] = '{1'b1, 4};

        rst_n = 1'b0; seed_wr = 1'b0; seed_idx = '0; seed_data = '0;
        seed_go = 1'b0; out_ready = 1'b1;

        repeat (2) @(negedge clk);
        check64("rst_valid", 64'(out_valid), 64'd0);
        check64("rst_u0", 64'(u0), 64'd0);
        check64("rst_u1", 64'(u1), 64'd0);

        ma0 = 32'h0000_1234 | 32'h2; ma1 = 32'h0000_5678 | 32'h8; ma2 = 32'h0000_9ABC | 32'h10;
        mb0 = 32'h1357_0000 | 32'h2; mb1 = 32'h2468_0000 | 32'h8; mb2 = 32'h369C_0000 | 32'h10;
        model_restart();
        rst_n = 1'b1;
        wait_first_valid("first_valid_after_reset");
        stream("seq_ready", 200, 1'b0);

        // Directed stall pattern
        idx = 0;
        foreach (tbl[k]) begin
            while (idx < tbl[k].off) begin
                next_sample(cur_exp);
                idx++;
            end
            check64("stall_valid", 64'(out_valid), 64'd1);
            check64("stall_data", {u0, u1}, cur_exp);
            out_ready = tbl[k].ready;
            @(negedge clk);
        end
        // last row had ready=1, so the next sample is now presented
        next_sample(cur_exp);

        stream("seq_random", 300, 1'b1);

        // Seed write while stalled
        out_ready = 1'b0;
        @(negedge clk);
        check64("pre_seed_valid", 64'(out_valid), 64'd1);
        seed_wr = 1'b1; seed_idx = 3'd0; seed_data = 32'h0;
        @(negedge clk);
        check64("seed_wr_clears_valid", 64'(out_valid), 64'd0);
        seed_idx = 3'd1;
        @(negedge clk);
        seed_idx = 3'd2;
        @(negedge clk);
        seed_idx = 3'd3; seed_go = 1'b1;
        @(negedge clk);
        seed_go = 1'b0; seed_idx = 3'd6; seed_data = 32'hFFFF_FFFF;
        @(negedge clk);
        seed_wr = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check64("load_no_output", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        ma0 = 32'd2; ma1 = 32'd8; ma2 = 32'd16; mb0 = 32'd2;
        model_restart();
        seed_go = 1'b1;
        @(negedge clk);
        seed_go = 1'b0;
        wait_first_valid("first_valid_after_go");
        stream("seq_zero_seed", 100, 1'b0);

        // seed_go outside LOAD is ignored: sequence continues undisturbed
        seed_go = 1'b1;
        stream("seq_go_in_run", 5, 1'b0);
        seed_go = 1'b0;

        // Asynchronous reset during a stall
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check64("stall_before_reset", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check64("async_rst_valid", 64'(out_valid), 64'd0);
        check64("async_rst_u", {u0, u1}, 64'd0);
        @(negedge clk);
        ma0 = 32'h0000_1234 | 32'h2; ma1 = 32'h0000_5678 | 32'h8; ma2 = 32'h0000_9ABC | 32'h10;
        mb0 = 32'h1357_0000 | 32'h2; mb1 = 32'h2468_0000 | 32'h8; mb2 = 32'h369C_0000 | 32'h10;
        model_restart();
        rst_n = 1'b1;
        wait_first_valid("first_valid_after_rerst");
        stream("seq_after_rerst", 50, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
